// File: rtl/inst_queue_param.sv
// Instruction FIFO between InstFetcher and Decoder. Issues one entry per cycle, steered by RS/LSB space.
// Optional same-cycle bypass of an empty queue is enabled by defining IQ_BYPASS_EN.
module inst_queue_param #(
  parameter int INST_W      = 32,
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int FULL_MARGIN = 1,
  localparam int PTR_W      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              IF_input_valid,
  input  logic [INST_W-1:0] IF_inst,
  input  logic [ADDR_W-1:0] IF_inst_pc,
  input  logic              IF_predicted_to_jump,
  input  logic [ADDR_W-1:0] IF_predicted_pc,
  output logic              IF_IQ_is_full,
  input  logic              ROB_is_full,
  input  logic              RS_is_full,
  input  logic              LSB_is_full,
  input  logic              ID_ready,
  output logic              ID_output_valid,
  output logic [INST_W-1:0] ID_inst,
  output logic [ADDR_W-1:0] ID_inst_pc,
  output logic              ID_predicted_to_jump,
  output logic [ADDR_W-1:0] ID_predicted_pc,
  input  logic              ROB_roll_back_flag,
  output logic [PTR_W:0]    IQ_count,
  output logic              IQ_overflow
);

  localparam logic [PTR_W:0] LP_DEPTH = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] LP_FULL  = (PTR_W+1)'(DEPTH - FULL_MARGIN);

  logic [INST_W-1:0] r_mem_inst [DEPTH];
  logic [ADDR_W-1:0] r_mem_pc   [DEPTH];
  logic              r_mem_pj   [DEPTH];
  logic [ADDR_W-1:0] r_mem_ppc  [DEPTH];

  logic [PTR_W-1:0]  r_head, r_tail;
  logic [PTR_W:0]    r_count;
  logic              r_out_valid, r_overflow;
  logic [INST_W-1:0] r_out_inst;
  logic [ADDR_W-1:0] r_out_pc, r_out_ppc;
  logic              r_out_pj;

  logic w_head_lsb, w_in_lsb, w_ready_common, w_issue, w_byp, w_enq, w_drop;

  // Loads and stores go to the LSB; everything else to the RS.
  assign w_head_lsb = (r_mem_inst[r_head][6:0] == 7'b0000011) ||
                      (r_mem_inst[r_head][6:0] == 7'b0100011);
  assign w_in_lsb   = (IF_inst[6:0] == 7'b0000011) || (IF_inst[6:0] == 7'b0100011);

  assign w_ready_common = ID_ready && !ROB_is_full;
  assign w_issue = (r_count != '0) && w_ready_common &&
                   !(w_head_lsb ? LSB_is_full : RS_is_full);

`ifdef IQ_BYPASS_EN
  assign w_byp = (r_count == '0) && IF_input_valid && w_ready_common &&
                 !(w_in_lsb ? LSB_is_full : RS_is_full);
`else
  assign w_byp = 1'b0;
`endif

  assign w_enq  = IF_input_valid && ((r_count < LP_DEPTH) || w_issue) && !w_byp;
  assign w_drop = IF_input_valid && (r_count == LP_DEPTH) && !w_issue;

  always_ff @(posedge clk) begin
    if (!rst && rdy && !ROB_roll_back_flag && w_enq) begin
      r_mem_inst[r_tail] <= IF_inst;
      r_mem_pc[r_tail]   <= IF_inst_pc;
      r_mem_pj[r_tail]   <= IF_predicted_to_jump;
      r_mem_ppc[r_tail]  <= IF_predicted_pc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
      r_out_inst  <= '0;
      r_out_pc    <= '0;
      r_out_pj    <= 1'b0;
      r_out_ppc   <= '0;
      r_overflow  <= 1'b0;
    end else if (!rdy) begin
      r_out_valid <= 1'b0;
    end else if (ROB_roll_back_flag) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_issue) begin
        r_out_inst  <= r_mem_inst[r_head];
        r_out_pc    <= r_mem_pc[r_head];
        r_out_pj    <= r_mem_pj[r_head];
        r_out_ppc   <= r_mem_ppc[r_head];
        r_out_valid <= 1'b1;
        r_head      <= r_head + PTR_W'(1);
      end else if (w_byp) begin
        r_out_inst  <= IF_inst;
        r_out_pc    <= IF_inst_pc;
        r_out_pj    <= IF_predicted_to_jump;
        r_out_ppc   <= IF_predicted_pc;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
      if (w_enq)  r_tail     <= r_tail + PTR_W'(1);
      if (w_drop) r_overflow <= 1'b1;
      case ({w_enq, w_issue})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign IF_IQ_is_full        = (r_count >= LP_FULL);
  assign IQ_count             = r_count;
  assign IQ_overflow          = r_overflow;
  assign ID_output_valid      = r_out_valid;
  assign ID_inst              = r_out_inst;
  assign ID_inst_pc           = r_out_pc;
  assign ID_predicted_to_jump = r_out_pj;
  assign ID_predicted_pc      = r_out_ppc;

endmodule
